// File: rtl/alu_pkg.sv
// Shared types for the ALU/MDU execution unit: op encodings and control states.
package alu_pkg;

    typedef enum logic [4:0] {
        OP_ADD    = 5'd0,
        OP_SUB    = 5'd1,
        OP_SLL    = 5'd2,
        OP_SLT    = 5'd3,
        OP_SLTU   = 5'd4,
        OP_XOR    = 5'd5,
        OP_SRL    = 5'd6,
        OP_SRA    = 5'd7,
        OP_OR     = 5'd8,
        OP_AND    = 5'd9,
        OP_MUL    = 5'd16,
        OP_MULH   = 5'd17,
        OP_MULHSU = 5'd18,
        OP_MULHU  = 5'd19,
        OP_DIV    = 5'd20,
        OP_DIVU   = 5'd21,
        OP_REM    = 5'd22,
        OP_REMU   = 5'd23
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_e;

    localparam logic [4:0] OP_MDU_BASE = 5'd16;
    localparam logic [4:0] OP_DIV_BASE = 5'd20;

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply/divide core: shift-add multiplier and restoring divider on
// operand magnitudes, one bit per cycle over a WIDTH-cycle down-counter.
module mdu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             kill,
    input  logic             start,
    input  logic [2:0]       op_lo,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             is_div_q, is_div_d;
    logic [1:0]       sel_q, sel_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;

    logic             st_is_div, st_signed_a, st_signed_b, st_neg_a, st_neg_b;
    logic [WIDTH-1:0] st_mag_a, st_mag_b;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift, div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] step_hi, step_lo;

    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH-1:0]   quo_s, rem_s;

    always_comb begin
        st_is_div   = op_lo[2];
        st_signed_a = st_is_div ? !op_lo[0] : (op_lo[1:0] == 2'd1 || op_lo[1:0] == 2'd2);
        st_signed_b = st_is_div ? !op_lo[0] : (op_lo[1:0] == 2'd1);
        st_neg_a    = st_signed_a & a[WIDTH-1];
        st_neg_b    = st_signed_b & b[WIDTH-1];
        st_mag_a    = st_neg_a ? -a : a;
        st_mag_b    = st_neg_b ? -b : b;
    end

    // Multiply: hi accumulates, lo holds the multiplier and collects low product bits.
    // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        div_ge    = !div_diff[WIDTH];
        if (is_div_q) begin
            step_hi = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            step_lo = {lo_q[WIDTH-2:0], div_ge};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        sel_d     = sel_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        if (kill) begin
            cnt_d     = '0;
            hi_d      = '0;
            lo_d      = '0;
            opnd_d    = '0;
            is_div_d  = 1'b0;
            sel_d     = '0;
            neg_quo_d = 1'b0;
            neg_rem_d = 1'b0;
        end else if (start) begin
            cnt_d     = CNT_W'(WIDTH);
            hi_d      = '0;
            lo_d      = st_is_div ? st_mag_a : st_mag_b;
            opnd_d    = st_is_div ? st_mag_b : st_mag_a;
            is_div_d  = st_is_div;
            sel_d     = op_lo[1:0];
            neg_quo_d = st_neg_a ^ st_neg_b;
            neg_rem_d = st_neg_a;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
            hi_d  = step_hi;
            lo_d  = step_lo;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            sel_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            sel_q     <= sel_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    // Final result is taken from the last step combinationally, so done marks the last iteration.
    assign done = (cnt_q == CNT_W'(1));

    always_comb begin
        prod   = {step_hi, step_lo};
        prod_s = neg_quo_q ? -prod : prod;
        quo_s  = neg_quo_q ? -step_lo : step_lo;
        rem_s  = neg_rem_q ? -step_hi : step_hi;
        if (is_div_q)
            result = sel_q[1] ? rem_s : quo_s;
        else
            result = (sel_q == 2'd0) ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH];
    end

endmodule

// File: rtl/alu_mdu.sv
// EX-stage ALU with RV32M extension behind a valid/ready handshake.
// state | meaning: IDLE accept op; BUSY iterative mul/div running; DONE result held until out_ready.
module alu_mdu
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             kill,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy
);

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    mdu_state_e       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;

    alu_op_e          op_e;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0] alu_res, special_res, fast_res, iter_res;
    logic             is_m, is_div, is_sdiv, div_zero, div_ovf, special;
    logic             accept, start, iter_done;

    assign op_e  = alu_op_e'(op);
    assign shamt = b[SHAMT_W-1:0];

    always_comb begin
        alu_res = '0;
        case (op_e)
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_SLL:  alu_res = a << shamt;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, a < b};
            OP_XOR:  alu_res = a ^ b;
            OP_SRL:  alu_res = a >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(a) >>> shamt);
            OP_OR:   alu_res = a | b;
            OP_AND:  alu_res = a & b;
            default: alu_res = '0;
        endcase
    end

    // Divide corner cases bypass the iterator and finish with single-cycle latency.
    always_comb begin
        is_m     = (op >= OP_MDU_BASE) && (op <= OP_REMU);
        is_div   = (op >= OP_DIV_BASE) && (op <= OP_REMU);
        is_sdiv  = (op_e == OP_DIV) || (op_e == OP_REM);
        div_zero = (b == '0);
        div_ovf  = is_sdiv && (a == MIN_VAL) && (b == '1);
        special  = is_div && (div_zero || div_ovf);
        if (div_zero)
            special_res = op[1] ? a : '1;
        else
            special_res = op[1] ? '0 : MIN_VAL;
        fast_res = special ? special_res : alu_res;
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_BUSY);
    assign accept    = in_valid && in_ready && !kill;
    assign start     = accept && is_m && !special;

    mdu_iter #(
        .WIDTH(WIDTH)
    ) u_mdu_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .kill   (kill),
        .start  (start),
        .op_lo  (op[2:0]),
        .a      (a),
        .b      (b),
        .done   (iter_done),
        .result (iter_res)
    );

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_BUSY;
                end else if (accept) begin
                    result_d = fast_res;
                    zero_d   = (fast_res == '0);
                    state_d  = ST_DONE;
                end
            end
            ST_BUSY: begin
                if (iter_done) begin
                    result_d = iter_res;
                    zero_d   = (iter_res == '0);
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (kill)
            state_d = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign result = result_q;
    assign zero   = zero_q;

endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
- Parametrised successor to the core combinational ALU.
- Executes the full RV32I ALU op set plus the RV32M multiply/divide ops behind a valid/ready handshake.
- Simple ops complete in 1 cycle; MUL*/DIV*/REM* iterate over WIDTH cycles.
- Sits in the EX stage. The pipeline stalls on in_ready/out_valid.

Parameters:
- WIDTH, 32, operand/result width; power of two, ≥8.
- SHAMT_W, $clog2(WIDTH), shift-amount bits taken from b[SHAMT_W-1:0].

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset: one clock; reset is synchronous and active-low.
- kill  input  1  abort the in-flight op (pipeline flush).
- in_valid  input  1  op/a/b valid.
- in_ready  output  1  unit can accept an op.
- op  input  5  operation select (encoding below).
- a  input  WIDTH  operand A (rs1).
- b  input  WIDTH  operand B (rs2/imm).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  registered result.
- zero  output  1  result == 0, registered with result.
- busy  output  1  high while an iterative op is in progress.

Behaviour:
- Op encoding:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT (signed), 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
  - 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU.
  - Any other code returns result 0 with zero=1, with 1-cycle latency.
- Arithmetic is modulo 2^WIDTH. Shifts use only b[SHAMT_W-1:0]. SLT/SLTU return 1 or 0 in the LSB.
- States: IDLE, BUSY, DONE. A transfer occurs on in_valid && in_ready; in_ready = (state==IDLE).
- Simple op accepted in cycle N: the next edge loads result/zero, state goes to DONE, out_valid=1 from cycle N+1.
- M op accepted in cycle N:
  - Entering BUSY: capture magnitudes and sign flags; iteration counter = WIDTH.
  - Multiply: shift-add, one partial-product bit per cycle. Divide: restoring, one quotient bit per cycle.
  - After WIDTH BUSY cycles, the sign fix-up and select are applied, then state goes to DONE. out_valid rises in cycle N+WIDTH+1.
- Signedness:
  - MULH: both operands signed. MULHSU: a signed, b unsigned. MULHU: both unsigned.
  - MUL returns the low WIDTH bits; MULH* return the high WIDTH bits of the 2·WIDTH product.
- Division special cases skip BUSY and complete with simple-op latency:
  - b==0: quotient = all ones, remainder = a.
  - Signed a==MIN, b==-1: quotient = MIN, remainder = 0.
- Signed-division signs: quotient negated if the operand signs differ; remainder takes the sign of a.
- DONE: result/zero/out_valid hold stable until out_ready=1.
  - out_valid && out_ready returns state to IDLE at the next edge.
  - in_ready stays 0 in DONE (no same-cycle back-to-back; one bubble per op).
- busy = (state==BUSY).
- kill=1 (any state) forces IDLE at the next edge and clears out_valid. The result is discarded and no out_valid is produced for the killed op.
  - kill in the same cycle as an in_valid transfer: the new op is dropped.
- rst_n=0 at an edge: state=IDLE; out_valid=0, result=0, zero=0, busy=0; counter and datapath regs cleared. Reset mid-BUSY abandons the op.
- Inputs are sampled only on the transfer edge. Changes to a/b/op during BUSY or DONE have no effect.

Decomposition:
- Shared package alu_pkg:
  - op enum alu_op_e (5-bit, encodings above);
  - state enum mdu_state_e;
  - localparams OP_MDU_BASE=16 and OP_DIV_BASE=20.
- One sub-module, mdu_iter: the multi-cycle shift-add multiplier / restoring divider core with start/done and a WIDTH-cycle counter.
- The simple-op combinational datapath and FSM stay in alu_mdu.

Test Plan:
- ADD a=0xFFFFFFFF, b=1, out_ready=1 -> out_valid at N+1, result=0, zero=1; IDLE at N+2.
- SRA a=0x80000000, b=0x24 (shamt 4) -> result=0xF8000000. SLT a=-1, b=1 -> 1. SLTU a=-1, b=1 -> 0.
- MULH a=0x80000000, b=2 -> busy 32 cycles, out_valid at N+33, result=0xFFFFFFFF. MUL 7×-3 -> 0xFFFFFFEB.
- DIV a=-7, b=2 -> quotient 0xFFFFFFFD; REM -> 0xFFFFFFFF. DIVU a=100, b=0 -> 0xFFFFFFFF in 1 cycle; REMU -> 100. DIV 0x80000000/-1 -> 0x80000000.
- Back-pressure: hold out_ready=0 for 5 cycles after DONE. result stays stable, in_ready=0, and a second in_valid is not accepted until the cycle after out_ready=1.
- kill asserted at BUSY cycle 10 of a DIVU -> no out_valid, in_ready=1 next cycle. rst_n=0 mid-BUSY -> all outputs 0 at the next edge; a following ADD works normally.
